// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesting cache controllers, the arbiter and the
// single backing memory. The arbiter takes the slave view; the environment
// (requesters plus memory) takes the master view.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  // Requester side
  logic [NUM_PORTS-1:0]        port_ren;
  logic [NUM_PORTS-1:0]        port_wen;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS*DATA_W-1:0] port_wdata;
  logic [NUM_PORTS-1:0]        port_grant;
  logic [NUM_PORTS-1:0]        port_stall;
  logic [DATA_W-1:0]           port_rdata;
  logic [NUM_PORTS-1:0]        port_data_valid;

  // Memory side
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_enable;
  logic                        mem_wr;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_data_valid;

  modport slave (
    input  port_ren, port_wen, port_addr, port_wdata,
    output port_grant, port_stall, port_rdata, port_data_valid,
    output mem_addr, mem_wdata, mem_enable, mem_wr,
    input  mem_rdata, mem_data_valid
  );

  modport master (
    output port_ren, port_wen, port_addr, port_wdata,
    input  port_grant, port_stall, port_rdata, port_data_valid,
    input  mem_addr, mem_wdata, mem_enable, mem_wr,
    output mem_rdata, mem_data_valid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Multi-port arbiter in front of a single fixed-latency memory. One port owns
// the memory at a time and keeps it for as long as it requests; read returns
// are steered back to the issuing port by a tag pipeline matched to MEM_LAT,
// so a new owner can start while the previous owner's reads are in flight.
module mem_port_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MEM_LAT       = 4,
  parameter int PRIORITY_MODE = 0   // 0: round-robin, 1: fixed, port 0 highest
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_PORTS);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        owner_id_q, owner_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [MEM_LAT-1:0]     tag_vld_q;
  logic [ID_W-1:0]        tag_id_q [MEM_LAT];

  logic [NUM_PORTS-1:0]   req;
  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic                   owner_vld;
  logic                   rd_issue;
  logic                   tag_hit;
  logic [ADDR_W-1:0]      addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]      wdata_arr [NUM_PORTS];

  assign req       = bus.port_ren | bus.port_wen;
  assign owner_vld = (state_q == S_OWNED);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = bus.port_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = bus.port_wdata[i*DATA_W +: DATA_W];
  end

  // Lowest requesting id; later (lower) hits overwrite earlier ones.
  function automatic logic [ID_W-1:0] fixed_pick(input logic [NUM_PORTS-1:0] r);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (r[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // First requester after `last` in circular order. Scanning from the far end
  // backwards lets the nearest candidate overwrite the others.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                              input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] cand;
    int              s;
    id = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      s = int'(last) + k;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      cand = ID_W'(s);
      if (r[cand]) id = cand;
    end
    return id;
  endfunction

  // Choose the next owner among the ports currently requesting.
  always_comb begin
    win_vld = |req;
    if (PRIORITY_MODE == 1) win_id = fixed_pick(req);
    else                    win_id = rr_pick(req, rr_ptr_q);
  end

  // Owner state register; rr_ptr starts at the last id so port 0 wins first.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_PORTS - 1);
    end else begin
      state_q    <= state_d;
      owner_id_q <= owner_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Next-owner logic: hold while the owner requests, otherwise hand off
  // directly to a waiting port or fall back to idle.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d    = state_q;
    owner_id_d = owner_id_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d    = S_OWNED;
          owner_id_d = win_id;
          rr_ptr_d   = win_id;
        end
      end
      S_OWNED: begin
        if (!req[owner_id_q]) begin
          if (win_vld) begin
            owner_id_d = win_id;
            rr_ptr_d   = win_id;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory drive from the current owner; a port with ren and wen is a write.
  always_comb begin
    bus.port_grant = '0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (owner_vld) begin
      bus.port_grant = NUM_PORTS'(1) << owner_id_q;
      bus.mem_enable = req[owner_id_q];
      bus.mem_wr     = bus.port_wen[owner_id_q];
      bus.mem_addr   = addr_arr[owner_id_q];
      bus.mem_wdata  = wdata_arr[owner_id_q];
    end
  end

  assign bus.port_stall = req & ~bus.port_grant;
  assign rd_issue       = bus.mem_enable & ~bus.mem_wr;

  // Tag valid pipeline: one stage per memory cycle, cleared on reset so that
  // returns of reads issued before reset are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_issue;
      for (int i = 1; i < MEM_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  // Tag id pipeline travelling alongside the valid bits.
  // NOTE: the ids are left unreset on purpose; they are only ever read
  // qualified by tag_vld_q, which does reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= owner_id_q;
    for (int i = 1; i < MEM_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  // Return routing: a memory strobe with no live tag reaches no port.
  assign tag_hit             = bus.mem_data_valid & tag_vld_q[MEM_LAT-1];
  assign bus.port_data_valid = tag_hit ? (NUM_PORTS'(1) << tag_id_q[MEM_LAT-1]) : '0;
  assign bus.port_rdata      = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance see
// the same requester traffic, each with its own fixed-latency memory. A
// transaction-level model predicts ownership and memory drive; expected read
// returns go into a queue that a negedge monitor drains and compares.
module tb_mem_port_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  typedef struct {
    int              port;
    int              due;
    logic [DW-1:0]   data;
  } ret_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   ren   = '0;
  logic [NP-1:0]   wen   = '0;
  logic [NP*AW-1:0] addr  = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic            spur  = 1'b0;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  logic [NP-1:0]   obs_grant [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference arbitration: plain scan over port numbers.
  function automatic int pick(input logic [NP-1:0] r, input int mode, input int last);
    if (mode == 1) begin
      for (int i = 0; i < NP; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= NP; k++) if (r[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic int onehot_id(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .PRIORITY_MODE(g)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.port_ren   = ren;
    assign bus.port_wen   = wen;
    assign bus.port_addr  = addr;
    assign bus.port_wdata = wdata;
    assign obs_grant[g]   = bus.port_grant;

    // Backing memory: fixed latency, unaffected by the arbiter's reset.
    logic          mv [LAT];
    logic [DW-1:0] md [LAT];
    initial for (int i = 0; i < LAT; i++) begin mv[i] = 1'b0; md[i] = '0; end
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin mv[i] <= mv[i-1]; md[i] <= md[i-1]; end
      mv[0] <= bus.mem_enable & ~bus.mem_wr;
      md[0] <= bus.mem_addr ^ 16'h5A5A;
    end
    assign bus.mem_data_valid = mv[LAT-1] | spur;
    assign bus.mem_rdata      = mv[LAT-1] ? md[LAT-1] : 16'hDEAD;

    // Reference model state: current owner (-1 = none) and last granted id.
    int   owner = -1;
    int   last  = NP - 1;
    ret_t sb[$];

    always @(posedge clk or negedge rst_n) begin
      logic [NP-1:0] r;
      if (!rst_n) begin
        owner = -1;
        last  = NP - 1;
        sb.delete();
      end else begin
        r = ren | wen;
        if (owner >= 0 && r[owner]) begin
          if (!wen[owner]) sb.push_back('{owner, cyc + LAT, addr[owner*AW +: AW] ^ 16'h5A5A});
        end else begin
          owner = pick(r, g, last);
          if (owner >= 0) last = owner;
        end
      end
    end

    // Monitor: compare every output mid-cycle; pop returns as they fall due.
    always @(negedge clk) begin
      logic [NP-1:0] r, eg, epdv;
      logic          en_e, wr_e;
      logic [AW-1:0] a_e;
      logic [DW-1:0] d_e;
      ret_t          e;
      r = ren | wen;
      eg = '0; epdv = '0; en_e = 1'b0; wr_e = 1'b0; a_e = '0; d_e = '0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        en_e      = r[owner];
        wr_e      = wen[owner];
        a_e       = addr[owner*AW +: AW];
        d_e       = wdata[owner*DW +: DW];
      end
      check($sformatf("m%0d grant", g), 64'(bus.port_grant), 64'(eg));
      check($sformatf("m%0d stall", g), 64'(bus.port_stall), 64'(r & ~eg));
      check($sformatf("m%0d mem_enable", g), 64'(bus.mem_enable), 64'(en_e));
      check($sformatf("m%0d mem_wr", g), 64'(bus.mem_wr), 64'(wr_e));
      check($sformatf("m%0d mem_addr", g), 64'(bus.mem_addr), 64'(a_e));
      check($sformatf("m%0d mem_wdata", g), 64'(bus.mem_wdata), 64'(d_e));
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        epdv[e.port] = 1'b1;
        check($sformatf("m%0d rdata", g), 64'(bus.port_rdata), 64'(e.data));
      end
      check($sformatf("m%0d data_valid", g), 64'(bus.port_data_valid), 64'(epdv));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    ren[p] = r;
    wen[p] = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  initial begin
    int            cnt [NP];
    int            len [NP];
    logic          is_wr [NP];
    int            order[$];
    int            exp_order [5];
    logic [NP-1:0] g0, prev_g;

    exp_order = '{0, 1, 2, 3, 0};
    tick(2);
    rst_n = 1'b1;

    // Single port read burst
    for (int k = 0; k < 8; k++) begin
      set_port(0, 1'b1, 1'b0, 16'h0010 + 16'(2 * k), '0);
      tick();
    end
    ren = '0;
    tick(LAT + 2);

    // Two ports raise ren together
    set_port(0, 1'b1, 1'b0, 16'h0100, '0);
    set_port(1, 1'b1, 1'b0, 16'h0200, '0);
    tick(4);
    ren[0] = 1'b0;
    tick(4);
    ren = '0;
    tick(LAT + 2);

    // Everyone requests; each owner drops after its third granted cycle
    reset_pulse();
    for (int p = 0; p < NP; p++) begin
      cnt[p] = 0;
      set_port(p, 1'b1, 1'b0, 16'(16'h1000 * (p + 1)), '0);
    end
    prev_g = '0;
    repeat (24) begin
      tick();
      g0 = obs_grant[0];
      if (g0 != '0 && g0 != prev_g) order.push_back(onehot_id(g0));
      prev_g = g0;
      for (int p = 0; p < NP; p++) begin
        if (g0[p]) begin
          cnt[p]++;
          ren[p] = (cnt[p] < 3);
          if (cnt[p] >= 3) cnt[p] = 0;
        end else begin
          ren[p] = 1'b1;
        end
      end
    end
    check("rr order length ok", 64'(order.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++)
      if (i < order.size()) check($sformatf("rr order[%0d]", i), 64'(order[i]), 64'(exp_order[i]));
    ren = '0;
    tick(LAT + 2);

    // Handoff while the first owner's reads are still in flight
    reset_pulse();
    set_port(1, 1'b1, 1'b0, 16'h0300, '0);
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1'b1, 1'b0, 16'h0020 + 16'(k), '0);
      tick();
    end
    ren[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      addr[1*AW +: AW] = 16'h0300 + 16'(k);
      tick();
    end
    ren = '0;
    tick(LAT + 2);

    // Write, then a port asserting both ren and wen
    set_port(2, 1'b0, 1'b1, 16'h0040, 16'hBEEF);
    tick(3);
    set_port(2, 1'b1, 1'b1, 16'h0042, 16'hCAFE);
    tick(2);
    ren = '0;
    wen = '0;
    tick(LAT + 2);

    // Reset two reads into a fill; stale returns must vanish
    reset_pulse();
    set_port(0, 1'b1, 1'b0, 16'h0500, '0);
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_port(1, 1'b1, 1'b0, 16'h0600, '0);
    tick();
    check("m0 port 0 first after reset", 64'(obs_grant[0]), 64'(4'b0001));
    check("m1 port 0 first after reset", 64'(obs_grant[1]), 64'(4'b0001));
    tick(3);
    ren = '0;
    tick(LAT + 2);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick(2);

    // Random bursts from all ports with stray memory strobes
    for (int p = 0; p < NP; p++) begin len[p] = 0; is_wr[p] = 1'b0; end
    repeat (400) begin
      for (int p = 0; p < NP; p++) begin
        if (len[p] == 0 && $urandom_range(0, 3) == 0) begin
          len[p]   = int'($urandom_range(1, 8));
          is_wr[p] = ($urandom_range(0, 3) == 0);
        end
        if (len[p] > 0) begin
          set_port(p, !is_wr[p] || ($urandom_range(0, 1) == 1), is_wr[p],
                   16'($urandom), 16'($urandom));
          len[p]--;
        end else begin
          ren[p] = 1'b0;
          wen[p] = 1'b0;
        end
      end
      spur = ($urandom_range(0, 9) == 0);
      tick();
    end
    ren  = '0;
    wen  = '0;
    spur = 1'b0;
    tick(LAT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised multi-port arbiter between the cache controllers (I-cache, D-cache, and any future requesters) and the single multicycle `memory4c` backing store. It replaces the fixed I-over-D priority steering in the CPU top level. It grants the memory to one port at a time and holds that grant for the whole burst or fill. Read returns are routed back to the issuing port through a latency-matched tag pipeline, so a new owner can start while an earlier owner's reads are still in flight.

## Interface
- NUM_PORTS, 2: number of requesters; legal range 2..8.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- MEM_LAT, 4: cycles from a read issued (`mem_enable & ~mem_wr`) to its `mem_data_valid`; legal range 1..8.
- PRIORITY_MODE, 0: arbitration mode.
  - 0: round-robin.
  - 1: fixed priority, port 0 highest.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- port_ren  in  NUM_PORTS  per-port read request; held for the whole fill.
- port_wen  in  NUM_PORTS  per-port write request.
- port_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- port_wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way.
- port_grant  out  NUM_PORTS  one-hot or zero; the current owner.
- port_stall  out  NUM_PORTS  (port_ren|port_wen) & ~port_grant, per port.
- port_rdata  out  DATA_W  mem_rdata, broadcast to all ports.
- port_data_valid  out  NUM_PORTS  read-return strobe for the port that issued that read.
- mem_addr  out  ADDR_W  owner address; 0 when there is no owner.
- mem_wdata  out  DATA_W  owner write data; 0 when there is no owner.
- mem_enable  out  1  owner ren|wen, gated by the grant.
- mem_wr  out  1  owner wen, gated by the grant.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  memory read-valid.

## Operation
- State is registered: `owner_vld`, `owner_id`, `rr_ptr` (last granted id), and the tag pipeline `tag_vld[MEM_LAT]` / `tag_id[MEM_LAT]`.
- Owner states:
  - IDLE (`owner_vld=0`) -> OWNED when any port requests; the chosen id is registered.
  - OWNED -> stays OWNED while the owner's ren|wen is high.
  - OWNED -> at the edge where the owner's ren|wen is low:
    - another port requesting: the next owner is chosen and registered at that same edge (direct handoff, no IDLE cycle);
    - otherwise: IDLE.
- A grant is never revoked while the owner requests; there is no preemption.
- Arbitration (PRIORITY_MODE=0): scan ids `rr_ptr+1, rr_ptr+2, …` modulo NUM_PORTS; the first requester wins. `rr_ptr` is loaded with the winner on every new grant.
- Arbitration (PRIORITY_MODE=1): lowest requesting id wins; `rr_ptr` is ignored.
- Memory drive:
  - `mem_enable = owner_vld & (ren|wen)[owner_id]`
  - `mem_wr = owner_vld & wen[owner_id]`
  - a port with ren and wen both high is treated as a write.
- Tag pipeline:
  - shifts every cycle;
  - stage 0 loads `vld = mem_enable & ~mem_wr`, `id = owner_id`.
- Return routing: `port_data_valid[i] = mem_data_valid & tag_vld[MEM_LAT-1] & (tag_id[MEM_LAT-1]==i)`.
  - `mem_data_valid` with no matching valid tag is dropped; no port sees it.
- Writes produce no tag and no `port_data_valid`.

## Timing
- Reset values:
  - `owner_vld=0`, `port_grant=0`;
  - `rr_ptr=NUM_PORTS-1`, so port 0 wins first in mode 0;
  - all `tag_vld=0`;
  - `mem_enable=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`;
  - `port_data_valid=0`, `port_stall` follows the inputs.
- Grant latency: a request first seen high in cycle t with no owner gets grant in t+1. `mem_enable` is high in t+1; `port_stall` is high in t only.
- Read latency through the block: a read issued in cycle c returns `port_data_valid` in c+MEM_LAT. The block adds no delay on the memory path.
- Handoff: the old owner drops in cycle t, so `mem_enable=0` in t. The new owner is granted and drives memory in t+1.
- In-flight reads of the old owner still return to the old owner after handoff.
- Simultaneous new requests:
  - mode 0: resolved by round-robin from `rr_ptr`;
  - mode 1: lowest id wins.
- Reset asserted mid-burst: all state clears immediately. Returns arriving after release of `rst_n` are discarded.

## Test plan
- Single port: NUM_PORTS=2, MEM_LAT=4, port 0 reads addr 0x0010..0x001E for 8 cycles starting in cycle 1.
  - Required: grant[0] from cycle 2, mem_addr follows port 0.
  - port_data_valid[0] in cycles 6..13; port_data_valid[1] never asserts.
- Contention, mode 1: both ports raise ren in the same cycle.
  - Required: port 0 is granted, port_stall[1]=1.
  - Port 1 is granted the cycle after port 0 drops ren.
- Round-robin, mode 0, NUM_PORTS=4: all ports request continuously; each owner drops after 2 cycles.
  - Required: grant order 0,1,2,3,0.
- Handoff with in-flight reads: port 0 reads 3 words, then drops; port 1 reads immediately after.
  - Required: port 0's 3 returns go to port_data_valid[0], port 1's returns go to port_data_valid[1].
  - No mis-routed strobe.
- Write: the owner holds wen with wdata 0xBEEF at addr 0x0040.
  - Required: mem_enable=1, mem_wr=1, mem_wdata=0xBEEF; no tag and no port_data_valid.
- Reset mid-fill: rst_n pulsed low 2 reads into a fill.
  - Required: grant=0 and mem_enable=0 at once.
  - Late mem_data_valid pulses produce no port_data_valid; port 0 wins first after release.
